tank_input_ctrl: RTL and testbench

- Input conditioning stage directly upstream of the ultra_tank core.
- Merges PS/2 key events and two MiSTer joysticks into the cabinet's active-low dual-lever tank controls, start lines and fire lines.
- Coin requests are shaped into fixed-width coin-switch pulses with holdoff and release lockout, so the game CPU never sees a stuck or bouncing coin mech.
- Instanced in emu between hps_io and ultra_tank, clocked on clk_sys (12 MHz).

---
 rtl/tank_input_pkg.sv | 94 +++++++++
 rtl/tank_input_ctrl_coin.sv | 71 +++++++
 rtl/tank_input_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tank_input_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_input_pkg.sv
// tank_input_pkg: shared definitions for the tank cabinet input stage.
//   - lever_n bit positions
//   - coin FSM state encoding
//   - PS/2 scan codes ({extended, code})
//   - key flag record
//   - helpers: ms-to-cycles, counter width, lever pair decode
// Optional feature macro used by the top: TANK_INPUT_AUTOFIRE_EN.
package tank_input_pkg;

    // lever_n = {W_Fw,W_Bk,X_Fw,X_Bk,Y_Fw,Y_Bk,Z_Fw,Z_Bk}
    localparam int LV_W_FW = 7;
    localparam int LV_W_BK = 6;
    localparam int LV_X_FW = 5;
    localparam int LV_X_BK = 4;
    localparam int LV_Y_FW = 3;
    localparam int LV_Y_BK = 2;
    localparam int LV_Z_FW = 1;
    localparam int LV_Z_BK = 0;

    typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF, WAIT_REL} coin_state_e;

    // Scan codes, bit 8 = E0 extended prefix
    localparam logic [8:0] SC_A_UP    = 9'h175;
    localparam logic [8:0] SC_A_DN    = 9'h172;
    localparam logic [8:0] SC_A_LF    = 9'h16B;
    localparam logic [8:0] SC_A_RT    = 9'h174;
    localparam logic [8:0] SC_A_FIRE  = 9'h014;
    localparam logic [8:0] SC_B_UP    = 9'h02D;
    localparam logic [8:0] SC_B_DN    = 9'h02B;
    localparam logic [8:0] SC_B_LF    = 9'h023;
    localparam logic [8:0] SC_B_RT    = 9'h034;
    localparam logic [8:0] SC_B_FIRE  = 9'h01C;
    localparam logic [8:0] SC_START1  = 9'h016;
    localparam logic [8:0] SC_START1B = 9'h005;
    localparam logic [8:0] SC_START2  = 9'h01E;
    localparam logic [8:0] SC_START2B = 9'h006;
    localparam logic [8:0] SC_COIN1   = 9'h02E;
    localparam logic [8:0] SC_COIN1B  = 9'h004;
    localparam logic [8:0] SC_COIN2   = 9'h036;

    typedef struct packed {
        logic a_up;
        logic a_dn;
        logic a_lf;
        logic a_rt;
        logic a_fire;
        logic b_up;
        logic b_dn;
        logic b_lf;
        logic b_rt;
        logic b_fire;
        logic start1;
        logic start2;
        logic coin1;
        logic coin2;
    } key_flags_t;

    // Never returns 0 so a count always lasts at least one cycle.
    function automatic int ms_to_cycles(input int ms, input int clk_hz);
        longint c;
        c = (longint'(ms) * longint'(clk_hz)) / 1000;
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic int af_half_cycles(input int clk_hz, input int af_hz);
        int h;
        h = (af_hz < 1) ? clk_hz : clk_hz / (2 * af_hz);
        return (h < 1) ? 1 : h;
    endfunction

    // Bits needed to hold n-1 (counters load n-1 and run down to 0).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // dir = {U,D,L,R}; result = asserted {Fw1,Bk1,Fw2,Bk2} for one player's
    // lever pair. Anything not in the table (opposing, triples) drives nothing.
    function automatic logic [3:0] lever_pair(input logic [3:0] dir);
        logic [3:0] r;
        case (dir)
            4'b1000: r = 4'b1010;   // U
            4'b0100: r = 4'b0101;   // D
            4'b0001: r = 4'b1001;   // R
            4'b0010: r = 4'b0110;   // L
            4'b1010: r = 4'b0010;   // UL
            4'b1001: r = 4'b1000;   // UR
            4'b0101: r = 4'b0100;   // DR
            4'b0110: r = 4'b0001;   // DL
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tank_input_ctrl_coin.sv
// tank_coin_pulser: turns a level coin request into one fixed-width
// active-low coin pulse, followed by a forced-high holdoff and a wait for
// release, so a held or bouncing request yields exactly one credit.
// Ports:
//   clk_i     clock
//   rst_ni    async active-low reset (returns to IDLE, coin_n_o high)
//   req_i     merged coin request, active high
//   coin_n_o  shaped coin switch, active low
module tank_coin_pulser
    import tank_input_pkg::*;
#(
    parameter int PULSE_CYC = 600000,
    parameter int HOLD_CYC  = 1200000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic coin_n_o
);

    localparam int MAXC = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
    localparam int CW   = cnt_width(MAXC);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    coin_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // Down-count saturates at 0; loads below override it.
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = HOLD_LD;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = WAIT_REL;
            end
            WAIT_REL: begin
                // A fresh request in the release cycle is picked up by IDLE.
                if (!req_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coin_n_o = (state_q != PULSE);
    end

endmodule

// File: rtl/tank_input_ctrl.sv
// tank_input_ctrl: input conditioning ahead of the ultra_tank core.
// Merges PS/2 key events and two joysticks into active-low dual-lever tank
// controls, start lines, fire lines and shaped coin pulses.
// Ports:
//   clk_sys   system clock (12 MHz in the cabinet)
//   Reset_n   async active-low reset
//   ps2_key   [10] event toggle, [9] pressed, [8:0] extended scan code
//   joy1/joy2 [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin
//   lever_n   {W_Fw,W_Bk,X_Fw,X_Bk,Y_Fw,Y_Bk,Z_Fw,Z_Bk}, active low
//   fire_a/b  fire, active high
//   start1_n/start2_n, coin1_n/coin2_n  active low
// Build option: define TANK_INPUT_AUTOFIRE_EN to make held fire toggle at
// AUTOFIRE_HZ instead of following the request level.
module tank_input_ctrl
    import tank_input_pkg::*;
#(
    parameter int CLK_HZ          = 12000000,
    parameter int COIN_PULSE_MS   = 50,
    parameter int COIN_HOLDOFF_MS = 100,
    parameter int AUTOFIRE_HZ     = 8
) (
    input  logic        clk_sys,
    input  logic        Reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    output logic [7:0]  lever_n,
    output logic        fire_a,
    output logic        fire_b,
    output logic        start1_n,
    output logic        start2_n,
    output logic        coin1_n,
    output logic        coin2_n
);

    localparam int COIN_PULSE_CYC = ms_to_cycles(COIN_PULSE_MS, CLK_HZ);
    localparam int COIN_HOLD_CYC  = ms_to_cycles(COIN_HOLDOFF_MS, CLK_HZ);

    // ---------------- key event latch ----------------
    logic       tog_q;
    key_flags_t keys_q, keys_d;

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            tog_q  <= 1'b0;
            keys_q <= '0;
        end else begin
            tog_q  <= ps2_key[10];
            keys_q <= keys_d;
        end
    end

    // A change of the toggle bit against its last registered value marks a
    // new event; the pressed bit then becomes the key's level.
    always_comb begin
        keys_d = keys_q;
        if (ps2_key[10] != tog_q) begin
            case (ps2_key[8:0])
                SC_A_UP:               keys_d.a_up   = ps2_key[9];
                SC_A_DN:               keys_d.a_dn   = ps2_key[9];
                SC_A_LF:               keys_d.a_lf   = ps2_key[9];
                SC_A_RT:               keys_d.a_rt   = ps2_key[9];
                SC_A_FIRE:             keys_d.a_fire = ps2_key[9];
                SC_B_UP:               keys_d.b_up   = ps2_key[9];
                SC_B_DN:               keys_d.b_dn   = ps2_key[9];
                SC_B_LF:               keys_d.b_lf   = ps2_key[9];
                SC_B_RT:               keys_d.b_rt   = ps2_key[9];
                SC_B_FIRE:             keys_d.b_fire = ps2_key[9];
                SC_START1, SC_START1B: keys_d.start1 = ps2_key[9];
                SC_START2, SC_START2B: keys_d.start2 = ps2_key[9];
                SC_COIN1, SC_COIN1B:   keys_d.coin1  = ps2_key[9];
                SC_COIN2:              keys_d.coin2  = ps2_key[9];
                default: ;
            endcase
        end
    end

    // ---------------- merge ----------------
    logic [3:0] dir_a, dir_b;   // {U,D,L,R}
    logic [1:0] fire_req, start_req, coin_req;
    logic       joy_coin;

    assign dir_a = {keys_q.a_up | joy1[3], keys_q.a_dn | joy1[2],
                    keys_q.a_lf | joy1[1], keys_q.a_rt | joy1[0]};
    assign dir_b = {keys_q.b_up | joy2[3], keys_q.b_dn | joy2[2],
                    keys_q.b_lf | joy2[1], keys_q.b_rt | joy2[0]};

    assign fire_req  = {keys_q.b_fire | joy2[4], keys_q.a_fire | joy1[4]};
    assign start_req = {keys_q.start2 | joy1[6] | joy2[6],
                        keys_q.start1 | joy1[5] | joy2[5]};
    // Joystick coin buttons from either pad feed both mechs.
    assign joy_coin  = joy1[7] | joy2[7];
    assign coin_req  = {keys_q.coin2 | joy_coin, keys_q.coin1 | joy_coin};

    logic unused_joy;
    assign unused_joy = ^{joy1[15:8], joy2[15:8]};

    // ---------------- registered levers / starts ----------------
    logic [7:0] lever_q, lever_d;
    logic [1:0] start_n_q;

    assign lever_d = ~{lever_pair(dir_a), lever_pair(dir_b)};

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            lever_q   <= '1;
            start_n_q <= 2'b11;
        end else begin
            lever_q   <= lever_d;
            start_n_q <= ~start_req;
        end
    end

    assign lever_n  = lever_q;
    assign start1_n = start_n_q[0];
    assign start2_n = start_n_q[1];

    // ---------------- fire ----------------
    logic [1:0] fire_q;

`ifdef TANK_INPUT_AUTOFIRE_EN
    localparam int AF_HALF = af_half_cycles(CLK_HZ, AUTOFIRE_HZ);
    localparam int AFW     = cnt_width(AF_HALF);
    localparam logic [AFW-1:0] AF_LAST = AFW'(AF_HALF - 1);

    logic [1:0][AFW-1:0] af_cnt_q, af_cnt_d;
    logic [1:0]          af_ph_q, af_ph_d, fire_d;

    // Phase 0 drives fire high, so the first held cycle fires; release
    // clears both phase and counter so every hold restarts identically.
    always_comb begin
        af_cnt_d = af_cnt_q;
        af_ph_d  = af_ph_q;
        fire_d   = '0;
        for (int p = 0; p < 2; p++) begin
            if (!fire_req[p]) begin
                af_cnt_d[p] = '0;
                af_ph_d[p]  = 1'b0;
                fire_d[p]   = 1'b0;
            end else begin
                fire_d[p] = ~af_ph_q[p];
                if (af_cnt_q[p] == AF_LAST) begin
                    af_cnt_d[p] = '0;
                    af_ph_d[p]  = ~af_ph_q[p];
                end else begin
                    af_cnt_d[p] = af_cnt_q[p] + AFW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            af_cnt_q <= '0;
            af_ph_q  <= '0;
            fire_q   <= '0;
        end else begin
            af_cnt_q <= af_cnt_d;
            af_ph_q  <= af_ph_d;
            fire_q   <= fire_d;
        end
    end
`else
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) fire_q <= '0;
        else          fire_q <= fire_req;
    end

    logic unused_af;
    assign unused_af = (AUTOFIRE_HZ != 0);
`endif

    assign fire_a = fire_q[0];
    assign fire_b = fire_q[1];

    // ---------------- coin shaping ----------------
    logic [1:0] coin_n;

    for (genvar i = 0; i < 2; i++) begin : g_coin
        tank_coin_pulser #(
            .PULSE_CYC(COIN_PULSE_CYC),
            .HOLD_CYC (COIN_HOLD_CYC)
        ) u_pulser (
            .clk_i   (clk_sys),
            .rst_ni  (Reset_n),
            .req_i   (coin_req[i]),
            .coin_n_o(coin_n[i])
        );
    end

    assign coin1_n = coin_n[0];
    assign coin2_n = coin_n[1];

endmodule

// File: tb/tb_tank_input_ctrl.sv
module tb_tank_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        Reset_n = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] joy1 = '0;
    logic [15:0] joy2 = '0;
    logic [7:0]  lever_n;
    logic        fire_a, fire_b, start1_n, start2_n, coin1_n, coin2_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    tank_input_ctrl #(
        .CLK_HZ(1000), .COIN_PULSE_MS(5), .COIN_HOLDOFF_MS(10), .AUTOFIRE_HZ(100)
    ) dut (
        .clk_sys(clk_sys), .Reset_n(Reset_n), .ps2_key(ps2_key),
        .joy1(joy1), .joy2(joy2), .lever_n(lever_n),
        .fire_a(fire_a), .fire_b(fire_b), .start1_n(start1_n), .start2_n(start2_n),
        .coin1_n(coin1_n), .coin2_n(coin2_n)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        int         cyc;
        logic [7:0] lv;
        logic       fa, fb, s1, s2;
        string      nm;
    } lvl_t;

    typedef struct {
        int    start;
        int    len;
    } pulse_t;

    lvl_t   lq[$];
    pulse_t cq[2][$];
    int     run[2] = '{0, 0};
    int     st[2]  = '{0, 0};

    localparam logic [13:0] RST_VEC = {8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    function automatic logic [13:0] outs();
        return {lever_n, fire_a, fire_b, start1_n, start2_n, coin1_n, coin2_n};
    endfunction

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic expect_lvl(input int dly, input logic [7:0] lv, input logic fa,
                              input logic fb, input logic s1, input logic s2, input string nm);
        lvl_t e;
        e.cyc = cyc + dly; e.lv = lv; e.fa = fa; e.fb = fb; e.s1 = s1; e.s2 = s2; e.nm = nm;
        lq.push_back(e);
    endtask

    // mask bit0 = coin1, bit1 = coin2
    task automatic expect_pulse(input logic [1:0] mask, input int dly, input int len);
        pulse_t p;
        p.start = cyc + dly; p.len = len;
        if (mask[0]) cq[0].push_back(p);
        if (mask[1]) cq[1].push_back(p);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic send_key(input logic [8:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    // Level monitor: compares outputs at the cycles the stimulus scheduled.
    always @(negedge clk_sys) begin : lvl_mon
        lvl_t e;
        while (lq.size() > 0 && lq[0].cyc <= cyc) begin
            e = lq.pop_front();
            checks++;
            if (e.cyc != cyc ||
                {lever_n, fire_a, fire_b, start1_n, start2_n} !== {e.lv, e.fa, e.fb, e.s1, e.s2}) begin
                errors++;
                $display("FAIL %s cyc %0d (due %0d): got lever_n=%h fa=%b fb=%b s1n=%b s2n=%b want lever_n=%h fa=%b fb=%b s1n=%b s2n=%b",
                         e.nm, cyc, e.cyc, lever_n, fire_a, fire_b, start1_n, start2_n,
                         e.lv, e.fa, e.fb, e.s1, e.s2);
            end
        end
    end

    // Coin monitor: measures every low pulse and checks it against the queue.
    always @(negedge clk_sys) begin : coin_mon
        logic [1:0] cn;
        pulse_t     p;
        cn = {coin2_n, coin1_n};
        for (int i = 0; i < 2; i++) begin
            if (!cn[i]) begin
                if (run[i] == 0) st[i] = cyc;
                run[i]++;
            end else if (run[i] > 0) begin
                checks++;
                if (cq[i].size() == 0) begin
                    errors++;
                    $display("FAIL coin%0d_unexpected got start=%0d len=%0d want no pulse", i + 1, st[i], run[i]);
                end else begin
                    p = cq[i].pop_front();
                    if (p.start != st[i] || p.len != run[i]) begin
                        errors++;
                        $display("FAIL coin%0d_pulse got start=%0d len=%0d want start=%0d len=%0d",
                                 i + 1, st[i], run[i], p.start, p.len);
                    end
                end
                run[i] = 0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 Reset_n = 1'b0;
        #1 chk("reset_initial", outs(), RST_VEC);
        tick(3);
        Reset_n = 1'b1;
        expect_lvl(1, 8'hFF, 0, 0, 1, 1, "idle");
        tick(2);

        // joystick levers, one cycle latency
        joy1 = 16'h0008; expect_lvl(1, 8'h5F, 0, 0, 1, 1, "joy_a_up");
        tick(3);
        joy1 = 16'h000A; expect_lvl(1, 8'hDF, 0, 0, 1, 1, "joy_a_upleft");
        tick(3);
        joy1 = 16'h000C; expect_lvl(1, 8'hFF, 0, 0, 1, 1, "joy_a_updown");
        tick(2);
        joy1 = 16'h0001; joy2 = 16'h0006; expect_lvl(1, 8'h6E, 0, 0, 1, 1, "joy_a_r_b_dl");
        tick(2);
        joy1 = '0; joy2 = '0; expect_lvl(1, 8'hFF, 0, 0, 1, 1, "joy_release");
        tick(2);
        joy1 = 16'h0030; joy2 = 16'h0050; expect_lvl(1, 8'hFF, 1, 1, 0, 0, "joy_fire_start");
        tick(2);
        joy1 = '0; joy2 = '0; expect_lvl(1, 8'hFF, 0, 0, 1, 1, "joy_fire_start_rel");
        tick(2);

        // PS/2 keys, two cycles from toggle to lever
        send_key(9'h034, 1'b1); expect_lvl(2, 8'hF6, 0, 0, 1, 1, "key_b_right");
        tick(4);
        send_key(9'h034, 1'b0); expect_lvl(2, 8'hFF, 0, 0, 1, 1, "key_b_right_rel");
        tick(4);
        send_key(9'h175, 1'b1);
        tick(1);
        joy2 = 16'h0004; expect_lvl(1, 8'h5A, 0, 0, 1, 1, "key_a_up_joy_b_dn");
        tick(3);
        send_key(9'h175, 1'b0); joy2 = '0; expect_lvl(2, 8'hFF, 0, 0, 1, 1, "key_a_up_rel");
        tick(3);
        send_key(9'h0AA, 1'b1); expect_lvl(2, 8'hFF, 0, 0, 1, 1, "key_unknown");
        tick(3);
        send_key(9'h016, 1'b1); expect_lvl(2, 8'hFF, 0, 0, 0, 1, "key_start1");
        tick(3);
        send_key(9'h016, 1'b0); expect_lvl(2, 8'hFF, 0, 0, 1, 1, "key_start1_rel");
        tick(3);
        send_key(9'h014, 1'b1); expect_lvl(2, 8'hFF, 1, 0, 1, 1, "key_fire_a");
        tick(3);
        send_key(9'h014, 1'b0); expect_lvl(2, 8'hFF, 0, 0, 1, 1, "key_fire_a_rel");
        tick(5);

        // coin held 40 cycles: one 5-cycle pulse; release and re-press: one more
        joy2 = 16'h0080; expect_pulse(2'b11, 1, 5);
        tick(40);
        joy2 = '0;
        tick(3);
        joy2 = 16'h0080; expect_pulse(2'b11, 1, 5);
        tick(2);
        joy2 = '0;
        tick(20);

        // 1-cycle request during holdoff is ignored
        joy1 = 16'h0080; expect_pulse(2'b11, 1, 5);
        tick(1);
        joy1 = '0;
        tick(7);
        joy1 = 16'h0080;
        tick(1);
        joy1 = '0;
        tick(15);

        // coin keys on separate mechs run independently
        send_key(9'h02E, 1'b1); expect_pulse(2'b01, 2, 5);
        tick(1);
        send_key(9'h036, 1'b1); expect_pulse(2'b10, 2, 5);
        tick(4);
        send_key(9'h02E, 1'b0);
        tick(1);
        send_key(9'h036, 1'b0);
        tick(20);

        // reset in the middle of a pulse: outputs return immediately
        joy1 = 16'h0088; expect_lvl(1, 8'h5F, 0, 0, 1, 1, "pre_reset_up"); expect_pulse(2'b11, 1, 2);
        tick(3);
        Reset_n = 1'b0; ps2_key = '0;
        #1 chk("reset_midsim", outs(), RST_VEC);
        joy1 = '0;
        tick(2);
        Reset_n = 1'b1; expect_lvl(1, 8'hFF, 0, 0, 1, 1, "post_reset");
        tick(3);

        // fire held for 20 cycles
        joy1 = 16'h0010;
        for (int k = 1; k <= 20; k++) begin
`ifdef TANK_INPUT_AUTOFIRE_EN
            expect_lvl(k, 8'hFF, (((k - 1) / 5) % 2) == 0, 0, 1, 1, "autofire");
`else
            expect_lvl(k, 8'hFF, 1'b1, 0, 1, 1, "fire_hold");
`endif
        end
        tick(20);
        joy1 = '0; expect_lvl(1, 8'hFF, 0, 0, 1, 1, "fire_release");
        tick(10);

        checks++;
        if (lq.size() != 0 || cq[0].size() != 0 || cq[1].size() != 0 || run[0] != 0 || run[1] != 0) begin
            errors++;
            $display("FAIL leftovers got lvl=%0d coin1=%0d coin2=%0d run1=%0d run2=%0d want all 0",
                     lq.size(), cq[0].size(), cq[1].size(), run[0], run[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
